// File: rtl/mc_alu_control_fsm_pkg.sv
// Shared encodings for the multicycle controller: ALU codes, instruction classes,
// FSM states, mux selects and trap causes.
package mc_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0011,
    ALU_CMP  = 4'b0100,
    ALU_BEQ  = 4'b0101,
    ALU_SLL  = 4'b1100,
    ALU_SLR  = 4'b1101,
    ALU_SLLV = 4'b1110,
    ALU_SLRV = 4'b1111
  } alu_code_t;

  typedef enum logic [2:0] {
    OP_RALU  = 3'd0,
    OP_IALU  = 3'd1,
    OP_LOAD  = 3'd2,
    OP_STORE = 3'd3,
    OP_BEQ   = 3'd4,
    OP_JUMP  = 3'd5
  } op_class_t;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_EXEC   = 4'd2,
    ST_MEM    = 4'd3,
    ST_WB     = 4'd4,
    ST_TRAP   = 4'd5
  } state_t;

  typedef enum logic [1:0] {
    PC_SRC_ALU    = 2'd0,
    PC_SRC_ALUOUT = 2'd1,
    PC_SRC_JUMP   = 2'd2,
    PC_SRC_TRAP   = 2'd3
  } pc_src_t;

  typedef enum logic [1:0] {
    SRC_B_REG     = 2'd0,
    SRC_B_FOUR    = 2'd1,
    SRC_B_IMM     = 2'd2,
    SRC_B_IMM_SH2 = 2'd3
  } src_b_t;

  typedef enum logic [1:0] {
    CAUSE_OVF         = 2'd0,
    CAUSE_ILLEGAL     = 2'd1,
    CAUSE_MEM_TIMEOUT = 2'd2
  } trap_cause_t;

  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_RALU) || (op == OP_IALU);
  endfunction

  // Only the signed add/subtract results are architecturally checked for overflow.
  function automatic logic traps_on_ovf(input logic [3:0] fn);
    return (fn == ALU_ADD) || (fn == ALU_SUB);
  endfunction

endpackage

// File: rtl/mc_alu_control_fsm_wait_timer.sv
// Wait-cycle counter for memory handshakes; at_limit marks the last wait cycle
// allowed before the controller gives up on the access.
module mc_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic at_limit
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign at_limit = (count == LAST);

endmodule

// File: rtl/mc_alu_control_fsm.sv
// Multicycle main controller: walks the shared ALU through fetch, decode, execute,
// memory and write-back, latches ALU flags and raises traps.
module mc_alu_control_fsm
  import mc_pkg::*;
#(
  parameter int          MEM_TIMEOUT = 16,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0080
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] op_class,
  input  logic [3:0] alu_fn,
  input  logic       alu_zero,
  input  logic       alu_neg,
  input  logic       alu_ovf,
  input  logic       alu_cout,
  input  logic       mem_ready,
  output logic [3:0] alu_ctrl,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       mem_to_reg,
  output logic [1:0] pc_src,
  output logic [3:0] flags,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [3:0] state
);

  // The trap vector itself is muxed in the datapath; here we only reject bad values.
  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_timeout
    $error("mc_alu_control_fsm: MEM_TIMEOUT must be in 1..255");
  end
  if (TRAP_VECTOR[1:0] != 2'b00) begin : g_bad_vector
    $error("mc_alu_control_fsm: TRAP_VECTOR must be word aligned");
  end

  state_t     cur_state, next_state;
  logic [2:0] op_q;
  logic [3:0] fn_q;
  logic [3:0] flags_q;
  logic [1:0] cause_q, next_cause;
  logic       wait_en, wait_at_limit, state_change;

  assign wait_en      = !reset && !mem_ready && (cur_state == ST_FETCH || cur_state == ST_MEM);
  assign state_change = (next_state != cur_state);

  mc_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_change),
    .enable   (wait_en),
    .at_limit (wait_at_limit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= ST_FETCH;
      op_q      <= '0;
      fn_q      <= '0;
      flags_q   <= '0;
      cause_q   <= '0;
    end else begin
      cur_state <= next_state;
      cause_q   <= next_cause;
      if (cur_state == ST_DECODE) begin
        op_q <= op_class;
        fn_q <= alu_fn;
      end
      if (cur_state == ST_EXEC && is_alu_op(op_q)) begin
        flags_q <= {alu_neg, alu_zero, alu_cout, alu_ovf};
      end
    end
  end

  // Reset forces every strobe low combinationally so an access in flight is abandoned.
  always_comb begin
    next_state = cur_state;
    next_cause = cause_q;
    alu_ctrl   = ALU_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_REG;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    mem_to_reg = 1'b0;
    pc_src     = PC_SRC_ALU;
    trap       = 1'b0;

    if (!reset) begin
      case (cur_state)
        ST_FETCH: begin
          mem_req   = 1'b1;
          ir_write  = 1'b1;
          alu_src_b = SRC_B_FOUR;
          pc_write  = mem_ready;
          if (mem_ready) begin
            next_state = ST_DECODE;
          end else if (wait_at_limit) begin
            next_state = ST_TRAP;
            next_cause = CAUSE_MEM_TIMEOUT;
          end
        end

        ST_DECODE: begin
          alu_src_b = SRC_B_IMM_SH2;
          if (op_class[2:1] == 2'b11) begin
            next_state = ST_TRAP;
            next_cause = CAUSE_ILLEGAL;
          end else if (op_class == OP_JUMP) begin
            pc_write   = 1'b1;
            pc_src     = PC_SRC_JUMP;
            next_state = ST_FETCH;
          end else begin
            next_state = ST_EXEC;
          end
        end

        ST_EXEC: begin
          alu_src_a = 1'b1;
          case (op_q)
            OP_RALU: begin
              alu_ctrl  = fn_q;
              alu_src_b = SRC_B_REG;
            end
            OP_IALU: begin
              alu_ctrl  = fn_q;
              alu_src_b = SRC_B_IMM;
            end
            OP_BEQ: begin
              alu_ctrl  = ALU_BEQ;
              alu_src_b = SRC_B_REG;
              pc_write  = alu_zero;
              pc_src    = PC_SRC_ALUOUT;
            end
            default: begin
              alu_ctrl  = ALU_ADD;
              alu_src_b = SRC_B_IMM;
            end
          endcase

          if (op_q == OP_BEQ) begin
            next_state = ST_FETCH;
          end else if (op_q == OP_LOAD || op_q == OP_STORE) begin
            next_state = ST_MEM;
          end else if (alu_ovf && traps_on_ovf(fn_q)) begin
            next_state = ST_TRAP;
            next_cause = CAUSE_OVF;
          end else begin
            next_state = ST_WB;
          end
        end

        ST_MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = (op_q == OP_STORE);
          if (mem_ready) begin
            next_state = (op_q == OP_STORE) ? ST_FETCH : ST_WB;
          end else if (wait_at_limit) begin
            next_state = ST_TRAP;
            next_cause = CAUSE_MEM_TIMEOUT;
          end
        end

        ST_WB: begin
          reg_write  = 1'b1;
          reg_dst    = (op_q == OP_RALU);
          mem_to_reg = (op_q == OP_LOAD);
          next_state = ST_FETCH;
        end

        ST_TRAP: begin
          trap       = 1'b1;
          pc_write   = 1'b1;
          pc_src     = PC_SRC_TRAP;
          next_state = ST_FETCH;
        end

        default: begin
          next_state = ST_FETCH;
        end
      endcase
    end
  end

  assign flags      = flags_q;
  assign trap_cause = cause_q;
  assign state      = cur_state;

endmodule
